control_fsm: RTL and testbench

CONTROL_FSM -- requirements
Module: control_fsm

---
 rtl/rv_ctrl_pkg.sv | 65 ++++++
 rtl/alu_decoder.sv | 32 +++
 rtl/control_fsm.sv | 149 ++++++++++++++
 tb/tb_control_fsm.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: opcodes, FSM states,
// ALU operation classes, ALU control codes and immediate formats.
package rv_ctrl_pkg;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpRtype  = 7'b0110011;
    localparam logic [6:0] OpItype  = 7'b0010011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpBranch = 7'b1100011;

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecuteR = 4'd6;
    localparam logic [3:0] StAluWb    = 4'd7;
    localparam logic [3:0] StExecuteI = 4'd8;
    localparam logic [3:0] StJal      = 4'd9;
    localparam logic [3:0] StBeq      = 4'd10;
    localparam logic [3:0] StIllegal  = 4'd11;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [2:0] AluCtlAdd = 3'b000;
    localparam logic [2:0] AluCtlSub = 3'b001;
    localparam logic [2:0] AluCtlAnd = 3'b010;
    localparam logic [2:0] AluCtlOr  = 3'b011;
    localparam logic [2:0] AluCtlSlt = 3'b101;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    // Moore outputs of one FSM state, before the branch/zero merge.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_write;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic [1:0] imm_src_decode(input logic [6:0] op);
        logic [1:0] imm;
        case (op)
            OpStore:  imm = ImmS;
            OpBranch: imm = ImmB;
            OpJal:    imm = ImmJ;
            default:  imm = ImmI;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU control decode from the FSM's aluOp class and the
// instruction's funct3 / op[5] / funct7[5] fields.
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] aluControl
);

    always_comb begin
        aluControl = AluCtlAdd;
        unique case (aluOp)
            AluOpAdd: aluControl = AluCtlAdd;
            AluOpSub: aluControl = AluCtlSub;
            AluOpFunct: begin
                case (funct3)
                    // funct7b5 only means sub for register ops; addi reuses the bit as immediate.
                    3'b000:  aluControl = (op5 && funct7b5) ? AluCtlSub : AluCtlAdd;
                    3'b010:  aluControl = AluCtlSlt;
                    3'b110:  aluControl = AluCtlOr;
                    3'b111:  aluControl = AluCtlAnd;
                    default: aluControl = AluCtlAdd;
                endcase
            end
            default: aluControl = AluCtlAdd;
        endcase
    end

endmodule

// File: rtl/control_fsm.sv
// Multicycle RV32I control FSM (Moore). Define RV_CTRL_ILLEGAL_TRAP_EN to trap
// unsupported opcodes in an absorbing ILLEGAL state; otherwise they run as NOPs.
module control_fsm
    import rv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pcWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       irWrite,
    output logic [1:0] resultSrc,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       regWrite,
    output logic [1:0] immSrc,
    output logic [2:0] aluControl,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] state_q, state_d;
    ctrl_t      ctl;

    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecuteR;
                    OpItype:         state_d = StExecuteI;
                    OpJal:           state_d = StJal;
                    OpBranch:        state_d = StBeq;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
                    default:         state_d = StIllegal;
`else
                    default:         state_d = StFetch;
`endif
                endcase
            end
            StMemAdr:   state_d = (op == OpStore) ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StBeq:      state_d = StFetch;
`ifdef RV_CTRL_ILLEGAL_TRAP_EN
            StIllegal:  state_d = StIllegal;
`else
            StIllegal:  state_d = StFetch;
`endif
            default:    state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ctl = '0;
        unique case (state_q)
            StFetch: begin
                ctl.ir_write   = 1'b1;
                ctl.alu_src_b  = 2'b10;
                ctl.result_src = 2'b10;
                ctl.pc_update  = 1'b1;
            end
            StDecode: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b01;
            end
            StMemAdr: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
            end
            StMemRead: ctl.adr_src = 1'b1;
            StMemWb: begin
                ctl.result_src = 2'b01;
                ctl.reg_write  = 1'b1;
            end
            StMemWrite: begin
                ctl.adr_src   = 1'b1;
                ctl.mem_write = 1'b1;
            end
            StExecuteR: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_op    = AluOpFunct;
            end
            StExecuteI: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_src_b = 2'b01;
                ctl.alu_op    = AluOpFunct;
            end
            StAluWb: ctl.reg_write = 1'b1;
            StJal: begin
                ctl.alu_src_a = 2'b01;
                ctl.alu_src_b = 2'b10;
                ctl.pc_update = 1'b1;
            end
            StBeq: begin
                ctl.alu_src_a = 2'b10;
                ctl.alu_op    = AluOpSub;
                ctl.branch    = 1'b1;
            end
            default: ctl = '0;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluOp      (ctl.alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .aluControl (aluControl)
    );

    // zero comes from the ALU in the same cycle, so the branch term stays combinational.
    assign pcWrite   = ctl.pc_update | (ctl.branch & zero);
    assign adrSrc    = ctl.adr_src;
    assign memWrite  = ctl.mem_write;
    assign irWrite   = ctl.ir_write;
    assign resultSrc = ctl.result_src;
    assign aluSrcA   = ctl.alu_src_a;
    assign aluSrcB   = ctl.alu_src_b;
    assign regWrite  = ctl.reg_write;
    assign immSrc    = imm_src_decode(op);
    assign state     = state_q;

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
    assign illegal = (state_q == StIllegal);
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class through its
// state sequence and checks every cycle's outputs against hand-written values.
module tb_control_fsm;

    logic       clk;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pcWrite, adrSrc, memWrite, irWrite, regWrite, illegal;
    logic [1:0] resultSrc, aluSrcA, aluSrcB, immSrc;
    logic [2:0] aluControl;
    logic [3:0] state;

    int n_total = 0;
    int n_bad   = 0;

    control_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pcWrite    (pcWrite),
        .adrSrc     (adrSrc),
        .memWrite   (memWrite),
        .irWrite    (irWrite),
        .resultSrc  (resultSrc),
        .aluSrcA    (aluSrcA),
        .aluSrcB    (aluSrcB),
        .regWrite   (regWrite),
        .immSrc     (immSrc),
        .aluControl (aluControl),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // {state, pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, regWrite}
    function automatic logic [14:0] exp_vec(input logic [3:0] st, input logic z);
        logic [14:0] v;
        case (st)
            4'd0:    v = {4'd0,  1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 2'b10, 1'b0};
            4'd1:    v = {4'd1,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 1'b0};
            4'd2:    v = {4'd2,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0};
            4'd3:    v = {4'd3,  1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
            4'd4:    v = {4'd4,  1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 1'b1};
            4'd5:    v = {4'd5,  1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0};
            4'd6:    v = {4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
            4'd7:    v = {4'd7,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b1};
            4'd8:    v = {4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 1'b0};
            4'd9:    v = {4'd9,  1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 1'b0};
            4'd10:   v = {4'd10, z,    1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 1'b0};
            default: v = {4'd11, 11'b0};
        endcase
        return v;
    endfunction

    function automatic logic [14:0] obs_vec();
        return {state, pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, regWrite};
    endfunction

    // Enter at a negedge in FETCH; seq holds up to six expected states, MSB nibble first.
    task automatic run_seq(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input logic z, input logic [23:0] seq, input int n,
                           input logic [1:0] imm, input logic [2:0] alu);
        logic [3:0] st;
        logic [2:0] alu_exp;
        op = o; funct3 = f3; funct7b5 = f7; zero = z;
        for (int i = 0; i < n; i++) begin
            #1;
            st = seq[23-4*i -: 4];
            alu_exp = (st == 4'd6 || st == 4'd8 || st == 4'd10) ? alu : 3'b000;
            check_eq($sformatf("%s[%0d] ctl", tag, i), 32'(obs_vec()), 32'(exp_vec(st, z)));
            check_eq($sformatf("%s[%0d] alu", tag, i), 32'(aluControl), 32'(alu_exp));
            check_eq($sformatf("%s[%0d] imm", tag, i), 32'(immSrc), 32'(imm));
            check_eq($sformatf("%s[%0d] ill", tag, i), 32'(illegal), 32'(st == 4'd11));
            if (i < n - 1) @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b1; op = 7'b0000011; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("reset ctl", 32'(obs_vec()), 32'(exp_vec(4'd0, 1'b0)));
        check_eq("reset ill", 32'(illegal), 32'd0);
        rst = 1'b0;

        run_seq("lw",   7'b0000011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 6,
                2'b00, 3'b000);
        run_seq("sw",   7'b0100011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}, 5,
                2'b01, 3'b000);
        run_seq("beq1", 7'b1100011, 3'b000, 1'b0, 1'b1, {4'd0, 4'd1, 4'd10, 4'd0, 8'd0}, 4,
                2'b10, 3'b001);
        run_seq("beq0", 7'b1100011, 3'b000, 1'b0, 1'b0, {4'd0, 4'd1, 4'd10, 4'd0, 8'd0}, 4,
                2'b10, 3'b001);
        run_seq("sub",  7'b0110011, 3'b000, 1'b1, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 5,
                2'b00, 3'b001);
        run_seq("add",  7'b0110011, 3'b000, 1'b0, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 5,
                2'b00, 3'b000);
        run_seq("or",   7'b0110011, 3'b110, 1'b0, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 5,
                2'b00, 3'b011);
        run_seq("and",  7'b0110011, 3'b111, 1'b0, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 5,
                2'b00, 3'b010);
        run_seq("slt",  7'b0110011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd0}, 5,
                2'b00, 3'b101);
        run_seq("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, {4'd0, 4'd1, 4'd8, 4'd7, 4'd0, 4'd0}, 5,
                2'b00, 3'b000);
        run_seq("jal",  7'b1101111, 3'b000, 1'b0, 1'b0, {4'd0, 4'd1, 4'd9, 4'd7, 4'd0, 4'd0}, 5,
                2'b11, 3'b000);

        // Asynchronous reset landing mid-instruction, between clock edges.
        run_seq("lwr",  7'b0000011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 8'd0}, 4,
                2'b00, 3'b000);
        #2 rst = 1'b1;
        #1;
        check_eq("async rst state", 32'(state), 32'd0);
        @(negedge clk);
        check_eq("rst held ctl", 32'(obs_vec()), 32'(exp_vec(4'd0, 1'b0)));
        rst = 1'b0;
        run_seq("lw2",  7'b0000011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0}, 6,
                2'b00, 3'b000);

`ifdef RV_CTRL_ILLEGAL_TRAP_EN
        run_seq("trap", 7'b0000000, 3'b000, 1'b0, 1'b0, {4'd0, 4'd1, 4'd11, 12'd0}, 3,
                2'b00, 3'b000);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            #1;
            check_eq($sformatf("trap hold[%0d] ctl", k), 32'(obs_vec()),
                     32'(exp_vec(4'd11, 1'b0)));
            check_eq($sformatf("trap hold[%0d] ill", k), 32'(illegal), 32'd1);
        end
        rst = 1'b1;
        #1;
        check_eq("trap rst state", 32'(state), 32'd0);
        check_eq("trap rst ill", 32'(illegal), 32'd0);
        @(negedge clk);
        rst = 1'b0;
`else
        run_seq("nop",  7'b0000000, 3'b000, 1'b0, 1'b0, {4'd0, 4'd1, 4'd0, 12'd0}, 3,
                2'b00, 3'b000);
`endif
        run_seq("post", 7'b0100011, 3'b010, 1'b0, 1'b0, {4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd0}, 5,
                2'b01, 3'b000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
